// File: rtl/maze_drawer_if.sv
// Signal bundle between the maze frame-scan engine, the maze ROM and the VGA adapter.
// master = the drawer, slave = the surrounding ROM / VGA / game FSM side.
interface maze_drawer_if;
  logic       start;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [7:0] rom_x;
  logic [6:0] rom_y;
  logic [2:0] rom_dout;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    input  start, player_x, player_y, rom_dout,
    output rom_x, rom_y, vga_x, vga_y, vga_colour, plot, busy, done
  );
  modport slave (
    output start, player_x, player_y, rom_dout,
    input  rom_x, rom_y, vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/maze_drawer.sv
// Raster-scans the maze ROM and streams (x, y, colour, plot) to the VGA adapter.
// Optional macro PLAYER_OVERLAY_EN paints the player's pixel with PLAYER_COLOUR.
module maze_drawer #(
  parameter int         WIDTH         = 160,
  parameter int         HEIGHT        = 120,
  parameter logic [2:0] PLAYER_COLOUR = 3'b100
) (
  input  logic          clk,
  input  logic          reset,
  maze_drawer_if.master bus
);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic last_x, last_y;
  assign last_x = (bus.rom_x == X_LAST);
  assign last_y = (bus.rom_y == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (last_x && last_y) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // VGA coordinates are captured from the address of the same edge, so they
  // line up with rom_dout, which the ROM registers on that edge as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rom_x <= '0;
      bus.rom_y <= '0;
      bus.vga_x <= '0;
      bus.vga_y <= '0;
      bus.plot  <= 1'b0;
    end else begin
      bus.plot <= (state == SCAN);
      if (state == SCAN) begin
        bus.vga_x <= bus.rom_x;
        bus.vga_y <= bus.rom_y;
        if (last_x) begin
          bus.rom_x <= '0;
          bus.rom_y <= last_y ? 7'd0 : bus.rom_y + 7'd1;
        end else begin
          bus.rom_x <= bus.rom_x + 8'd1;
        end
      end else begin
        bus.rom_x <= '0;
        bus.rom_y <= '0;
      end
    end
  end

`ifdef PLAYER_OVERLAY_EN
  logic hit;
  always_ff @(posedge clk) begin
    if (reset) hit <= 1'b0;
    else       hit <= (state == SCAN) && (bus.rom_x == bus.player_x) &&
                      (bus.rom_y == bus.player_y);
  end
`endif

  always_comb begin
    bus.busy       = (state == SCAN) || (state == FLUSH);
    bus.done       = (state == DONE);
`ifdef PLAYER_OVERLAY_EN
    bus.vga_colour = hit ? PLAYER_COLOUR : bus.rom_dout;
`else
    bus.vga_colour = bus.rom_dout;
`endif
  end
endmodule

// File: tb/tb_maze_drawer.sv
// Directed bench for maze_drawer: reset, full frames, row wrap, start held, reset mid-scan, overlay.
module tb_maze_drawer;
  localparam int PX = 10;
  localparam int PY = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  maze_drawer_if bus ();

  maze_drawer dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  // Registered ROM model: M[a] = a mod 8
  always @(posedge clk) bus.rom_dout <= 3'((int'(bus.rom_y) * 160 + int'(bus.rom_x)) % 8);

  int vecs = 0, miscmp = 0;
  int n_run, perr, first_bad, done_cnt, done_ok, gap, nx_x, nx_y, post_rst_plot;
  int f0x, f0y, f0c, w0x, w0y, w1x, w1y, lx, ly, lc, pcol;

  task automatic chk(input string tag, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_col(input int x, input int y);
`ifdef PLAYER_OVERLAY_EN
    if (x == PX && y == PY) return 4;
`endif
    return (y * 160 + x) % 8;
  endfunction

  // Samples on negedges for ncyc cycles; phase 0 = waiting, 1 = in plot run,
  // 2 = run ended, 3 = a following frame has begun.
  task automatic watch(input int ncyc, input int rst_at, input int pulse_at);
    int ph, ex, ey, c;
    ph = 0; n_run = 0; perr = 0; first_bad = -1; done_cnt = 0; done_ok = 0;
    gap = -1; nx_x = -1; nx_y = -1; post_rst_plot = -1; pcol = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (reset) begin
        post_rst_plot = int'(bus.plot);
        reset = 1'b0;
      end
      if (bus.done === 1'b1 && ph < 3) done_cnt++;
      if (ph <= 1) begin
        if (bus.plot === 1'b1) begin
          ex = n_run % 160; ey = n_run / 160; c = int'(bus.vga_colour);
          if (int'(bus.vga_x) != ex || int'(bus.vga_y) != ey || c != exp_col(ex, ey)) begin
            perr++;
            if (first_bad < 0) first_bad = n_run;
          end
          if (n_run == 0)     begin f0x = int'(bus.vga_x); f0y = int'(bus.vga_y); f0c = c; end
          if (n_run == 159)   begin w0x = int'(bus.vga_x); w0y = int'(bus.vga_y); end
          if (n_run == 160)   begin w1x = int'(bus.vga_x); w1y = int'(bus.vga_y); end
          if (n_run == 19199) begin lx = int'(bus.vga_x); ly = int'(bus.vga_y); lc = c; end
          if (int'(bus.vga_x) == PX && int'(bus.vga_y) == PY) pcol = c;
          n_run++;
          ph = 1;
          if (n_run == rst_at) reset = 1'b1;
          if (pulse_at >= 0 && n_run == pulse_at - 1) bus.start = 1'b0;
          if (pulse_at >= 0 && n_run == pulse_at) bus.start = 1'b1;
        end else if (ph == 1) begin
          ph = 2; gap = 1;
          done_ok = int'(bus.done === 1'b1 && bus.busy === 1'b0);
        end
      end else if (ph == 2) begin
        if (bus.plot === 1'b1) begin
          ph = 3; nx_x = int'(bus.vga_x); nx_y = int'(bus.vga_y);
        end else gap++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.player_x = 8'(PX); bus.player_y = 7'(PY);

    // 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_plot",  int'(bus.plot),  0);
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_done",  int'(bus.done),  0);
    chk("rst_rom_x", int'(bus.rom_x), 0);
    chk("rst_rom_y", int'(bus.rom_y), 0);
    chk("rst_vga_x", int'(bus.vga_x), 0);
    chk("rst_vga_y", int'(bus.vga_y), 0);
    reset = 1'b0;

    // 2/3/6: one full frame
    pulse_start();
    chk("busy_after_start", int'(bus.busy), 1);
    chk("plot_first_scan",  int'(bus.plot), 0);
    watch(19230, -1, -1);
    chk("frame_plots", n_run, 19200);
    chk("pix_err", perr, 0);
    chk("first_bad_pix", first_bad, -1);
    chk("first_x", f0x, 0);
    chk("first_y", f0y, 0);
    chk("first_c", f0c, 0);
    chk("wrap_a_x", w0x, 159);
    chk("wrap_a_y", w0y, 0);
    chk("wrap_b_x", w1x, 0);
    chk("wrap_b_y", w1y, 1);
    chk("last_x", lx, 159);
    chk("last_y", ly, 119);
    chk("last_c", lc, 7);
    chk("done_cycles", done_cnt, 1);
    chk("done_after_last", done_ok, 1);
    chk("idle_busy", int'(bus.busy), 0);
`ifdef PLAYER_OVERLAY_EN
    chk("player_colour", pcol, 4);
`else
    chk("player_colour", pcol, 2);
`endif

    // 4: start held high, extra pulse mid-frame
    @(negedge clk) bus.start = 1'b1;
    watch(19230, -1, 5000);
    bus.start = 1'b0;
    chk("held_plots", n_run, 19200);
    chk("held_pix_err", perr, 0);
    chk("held_done", done_cnt, 1);
    chk("held_done_slot", done_ok, 1);
    chk("restart_gap", gap, 3);
    chk("restart_x", nx_x, 0);
    chk("restart_y", nx_y, 0);

    // 5: reset mid-scan, then a fresh frame
    do_reset();
    pulse_start();
    watch(8010, 8000, -1);
    chk("rst_run_plots", n_run, 8000);
    chk("plot_after_rst", post_rst_plot, 0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_pix_err", perr, 0);
    chk("rst_rom_x_idle", int'(bus.rom_x), 0);
    chk("rst_rom_y_idle", int'(bus.rom_y), 0);
    chk("rst_busy_idle", int'(bus.busy), 0);
    pulse_start();
    watch(19230, -1, -1);
    chk("fresh_plots", n_run, 19200);
    chk("fresh_pix_err", perr, 0);
    chk("fresh_first_x", f0x, 0);
    chk("fresh_first_y", f0y, 0);
    chk("fresh_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule

// File: doc/maze_drawer.md
Name: maze_drawer

Overview:
Frame-scan engine downstream of the 160x120 maze ROM.
- On a start pulse it walks every pixel in raster order and drives the ROM x/y address.
- It absorbs the ROM's 1-cycle registered read latency and emits matched (x, y, colour, plot) writes to the VGA adapter, one pixel per clock.
- It signals busy during the scan and pulses done at the end so the game FSM can sequence redraws.

Parameters:
WIDTH, 160, pixels per row; x counter range 0..WIDTH-1.
HEIGHT, 120, rows per frame; y counter range 0..HEIGHT-1.
PLAYER_COLOUR, 3'b100, colour substituted at the player position (optional feature only).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin one full-frame draw; sampled only in IDLE.
player_x  input  8  player column; used only with the optional feature.
player_y  input  7  player row; used only with the optional feature.
rom_x  output  8  ROM column address.
rom_y  output  7  ROM row address.
rom_dout  input  3  ROM colour, registered in the ROM, valid 1 cycle after address.
vga_x  output  8  pixel column to VGA adapter.
vga_y  output  7  pixel row to VGA adapter.
vga_colour  output  3  pixel colour to VGA adapter.
plot  output  1  write strobe; VGA writes (vga_x, vga_y, vga_colour) when high.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  single-cycle pulse after the last plot.

Behaviour:
- Reset (synchronous, active-high), sampled at a clock edge with reset=1:
  - state=IDLE.
  - rom_x=0, rom_y=0, vga_x=0, vga_y=0.
  - plot=0, busy=0, done=0.
  - vga_colour follows rom_dout; it is don't-care while plot=0.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE: hold rom_x=rom_y=0. On an edge with start=1: go to SCAN, busy<=1.
- SCAN: each edge registers vga_x<=rom_x, vga_y<=rom_y, plot<=1, then advances the address:
  - if rom_x==WIDTH-1: rom_x<=0.
    - if rom_y==HEIGHT-1: rom_y<=0 and go to FLUSH.
    - else rom_y<=rom_y+1.
  - else rom_x<=rom_x+1.
- FLUSH: one cycle. plot is high for the final pixel (WIDTH-1, HEIGHT-1). Next edge: plot<=0, done<=1, busy<=0, go to DONE.
- DONE: one cycle with done=1. Next edge: done<=0, go to IDLE.
- Pipeline alignment:
  - The address presented in cycle n appears on rom_dout in cycle n+1.
  - vga_x/vga_y/plot are registered in that same edge, so all four VGA signals are coherent in cycle n+1.
  - vga_colour = rom_dout combinationally (already registered in the ROM).
- Latency:
  - Start accepted at edge E0; first plot (0,0) is high during the cycle after E1.
  - Last plot is high during the cycle after E19200.
  - done is high during the cycle after E19201.
  - Exactly WIDTH*HEIGHT = 19200 plot cycles, contiguous, no gaps.
- start while busy or in DONE: ignored; no restart and no queued request.
- Reset mid-scan: plot drops to 0 in the cycle after the reset edge. No done pulse. Counters return to 0.
- Arithmetic: counters compare against WIDTH-1/HEIGHT-1 explicitly. No reliance on natural wrap (8-bit x would otherwise reach 255).

Optional Feature:
Macro PLAYER_OVERLAY_EN.
- Defined:
  - a registered flag is set in the same edge as vga_x/vga_y, true when rom_x==player_x and rom_y==player_y.
  - when the flag is set, vga_colour=PLAYER_COLOUR; otherwise vga_colour=rom_dout.
  - player_x/player_y are sampled live each SCAN cycle.
- Undefined: player_x/player_y are ignored and vga_colour=rom_dout always. Ports remain present in both cases.

Test Plan:
1. Reset asserted 3 cycles -> plot=0, busy=0, done=0, rom_x=0, rom_y=0, vga_x=0, vga_y=0.
2. ROM model with M[a]=a mod 8; start pulse 1 cycle -> exactly 19200 plot cycles; each (vga_x, vga_y, vga_colour) equals (x, y, (y*160+x) mod 8); first plot is (0,0,0).
3. Row wrap -> plot sequence contains (159,0) immediately followed by (0,1); final plot is (159,119,(19199 mod 8)=7); done is high exactly 1 cycle, the cycle after the last plot, with busy=0 in that cycle.
4. start held high for the whole scan plus start pulse at pixel 5000 -> single frame of 19200 plots; next frame begins only after return to IDLE with start still high.
5. reset at plot count 8000 -> plot=0 in the next cycle; no done pulse; a fresh start yields a full 19200-plot frame from (0,0).
6. PLAYER_OVERLAY_EN defined, player=(10,20) -> pixel (10,20) plotted with colour 3'b100; all others match the ROM. Undefined -> (10,20) has colour M[3210]=2.
